// File: rtl/peripheral_uart_bus_master_pkg.sv
// Shared types and bus widths for the peripheral bus initiator.
//   op_t    : command opcode as carried on cmd_op
//   state_t : initiator FSM states
package peripheral_uart_bus_master_pkg;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned DATA_W = 16;

    typedef enum logic [1:0] {
        OpWrite   = 2'b00,
        OpRead    = 2'b01,
        OpPoll    = 2'b10,
        OpIllegal = 2'b11
    } op_t;

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StCapture,
        StResp
    } state_t;

endpackage

// File: rtl/peripheral_uart_bus_master.sv
// Peripheral bus initiator: runs single write, read and poll-until-match commands.
// Ports:
//   mclk, puc_rst        : clock, synchronous active-high reset
//   cmd_*                : valid/ready command port (op, addr, wdata, be, mask, timeout)
//   rsp_*                : valid/ready response port (rdata, err)
//   per_addr/din/en/we   : bus request pins, driven only in the access cycle
//   per_dout             : registered read data, valid the cycle after per_en
module peripheral_uart_bus_master
    import peripheral_uart_bus_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_W = 16
) (
    input  logic                 mclk,
    input  logic                 puc_rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [ADDR_W-1:0]    cmd_addr,
    input  logic [DATA_W-1:0]    cmd_wdata,
    input  logic [1:0]           cmd_be,
    input  logic [DATA_W-1:0]    cmd_mask,
    input  logic [TIMEOUT_W-1:0] cmd_timeout,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [DATA_W-1:0]    rsp_rdata,
    output logic                 rsp_err,
    output logic [ADDR_W-1:0]    per_addr,
    output logic [DATA_W-1:0]    per_din,
    output logic                 per_en,
    output logic [1:0]           per_we,
    input  logic [DATA_W-1:0]    per_dout
);

    state_t                state_q, state_d;
    op_t                   op_q, op_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [1:0]            be_q, be_d;
    logic [DATA_W-1:0]     mask_q, mask_d;
    logic [TIMEOUT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  err_q, err_d;
    op_t                   cmd_op_t;

    assign cmd_op_t = op_t'(cmd_op);

    always_ff @(posedge mclk) begin
        if (puc_rst) begin
            state_q <= StIdle;
            op_q    <= OpWrite;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            mask_q  <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        mask_d  = mask_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                if (cmd_valid) begin
                    op_d    = cmd_op_t;
                    addr_d  = cmd_addr;
                    wdata_d = cmd_wdata;
                    be_d    = cmd_be;
                    mask_d  = cmd_mask;
                    cnt_d   = cmd_timeout;
                    rdata_d = '0;
                    err_d   = 1'b0;
                    // Rejected commands never touch the bus.
                    if (cmd_op_t == OpIllegal || (cmd_op_t == OpWrite && cmd_be == 2'b00)) begin
                        err_d   = 1'b1;
                        state_d = StResp;
                    end else begin
                        state_d = StAccess;
                    end
                end
            end
            StAccess: begin
                state_d = (op_q == OpWrite) ? StResp : StCapture;
            end
            StCapture: begin
                rdata_d = per_dout;
                state_d = StResp;
                if (op_q == OpPoll && ((per_dout ^ wdata_q) & mask_q) != '0) begin
                    if (cnt_q == '0) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d   = cnt_q - TIMEOUT_W'(1);
                        state_d = StAccess;
                    end
                end
            end
            StResp: begin
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs decode from state only; per_* are held at zero outside the access cycle.
    always_comb begin
        cmd_ready = (state_q == StIdle) && !puc_rst;
        rsp_valid = (state_q == StResp);
        rsp_rdata = rsp_valid ? rdata_q : '0;
        rsp_err   = rsp_valid ? err_q : 1'b0;
        per_en    = (state_q == StAccess);
        per_addr  = per_en ? addr_q : '0;
        per_we    = (per_en && op_q == OpWrite) ? be_q : 2'b00;
        per_din   = (per_en && op_q == OpWrite) ? wdata_q : '0;
    end

endmodule
